mod_arith_seq: RTL and testbench



---
 rtl/mod_arith_pkg.sv | 26 ++
 rtl/mod_arith_seq.sv | 152 +++++++++++++++
 tb/tb_mod_arith_seq.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mod_arith_pkg.sv
// Shared encodings for the modular-arithmetic instruction decoder and its
// command sequencer.
package mod_arith_pkg;

    typedef enum logic [1:0] {
        INST_MUL_INIT = 2'b00,
        INST_DIV_INIT = 2'b01,
        INST_NEXT     = 2'b10,
        INST_CLEAR    = 2'b11
    } inst_op_e;

    typedef enum logic [1:0] {
        MQRTR    = 2'b00,
        MHLV     = 2'b01,
        MADD     = 2'b10,
        MADD_SWP = 2'b11
    } micro_op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        INIT  = 2'b01,
        ISSUE = 2'b10,
        DONE  = 2'b11
    } seq_state_e;

endpackage

// File: rtl/mod_arith_seq.sv
// Command sequencer: initialises the decoder for one MUL/DIV request, streams
// decoded micro-ops to the datapath over valid/ready, and clears the decoder.
module mod_arith_seq
    import mod_arith_pkg::*;
#(
    parameter int unsigned MAX_STEPS = 1023,
    parameter int unsigned CNT_W     = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             start_mul,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] step_cnt,
    output logic [1:0]       inst_op,
    output logic             inst_en,
    input  logic [1:0]       inst_nxt,
    input  logic             inst_last,
    output logic             dp_valid,
    output logic [1:0]       dp_op,
    input  logic             dp_ready
);

    seq_state_e       state_q, state_d;
    logic             mul_q, mul_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             valid_q, valid_d;
    logic [1:0]       op_q, op_d;

    inst_op_e         inst_op_c;
    logic             inst_en_c;
    logic             hs;
    logic [CNT_W-1:0] cnt_inc;

    assign hs      = valid_q & dp_ready;
    assign cnt_inc = cnt_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        mul_d     = mul_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        err_d     = err_q;
        valid_d   = valid_q;
        op_d      = op_q;
        inst_en_c = 1'b0;
        inst_op_c = INST_CLEAR;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = INIT;
                    mul_d   = start_mul;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    err_d   = 1'b0;
                end
            end
            INIT: begin
                inst_en_c = 1'b1;
                if (abort) begin
                    inst_op_c = INST_CLEAR;
                    valid_d   = 1'b0;
                    err_d     = 1'b1;
                    state_d   = DONE;
                end else begin
                    inst_op_c = mul_q ? INST_MUL_INIT : INST_DIV_INIT;
                    op_d      = inst_nxt;
                    valid_d   = 1'b1;
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                // abort wins over a simultaneous handshake and does not count it
                if (abort) begin
                    inst_en_c = 1'b1;
                    inst_op_c = INST_CLEAR;
                    valid_d   = 1'b0;
                    err_d     = 1'b1;
                    state_d   = DONE;
                end else if (hs) begin
                    inst_en_c = 1'b1;
                    cnt_d     = cnt_inc;
                    if (inst_last) begin
                        inst_op_c = INST_CLEAR;
                        valid_d   = 1'b0;
                        err_d     = 1'b0;
                        state_d   = DONE;
                    end else if (cnt_inc == CNT_W'(MAX_STEPS)) begin
                        inst_op_c = INST_CLEAR;
                        valid_d   = 1'b0;
                        err_d     = 1'b1;
                        state_d   = DONE;
                    end else begin
                        inst_op_c = INST_NEXT;
                        op_d      = inst_nxt;
                    end
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        done_d = (state_q != DONE) && (state_d == DONE);

        if (!rst_n) begin
            inst_en_c = 1'b0;
            inst_op_c = INST_CLEAR;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            mul_q   <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            mul_q   <= mul_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            valid_q <= valid_d;
            op_q    <= op_d;
        end
    end

    assign inst_en  = inst_en_c;
    assign inst_op  = inst_op_c;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;
    assign step_cnt = cnt_q;
    assign dp_valid = valid_q;
    assign dp_op    = op_q;

endmodule

// File: tb/tb_mod_arith_seq.sv
// Directed bench for mod_arith_seq with a scripted decoder model.
module tb_mod_arith_seq;

    localparam int CNT_W = 10;

    logic             clk = 1'b0;
    logic             rst_n, start, start_mul, abort, inst_last, dp_ready;
    logic             busy, done, err, inst_en, dp_valid;
    logic [CNT_W-1:0] step_cnt;
    logic [1:0]       inst_op, inst_nxt, dp_op;

    always #5 clk = ~clk;

    mod_arith_seq #(.MAX_STEPS(4), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .start_mul(start_mul),
        .abort(abort), .busy(busy), .done(done), .err(err),
        .step_cnt(step_cnt), .inst_op(inst_op), .inst_en(inst_en),
        .inst_nxt(inst_nxt), .inst_last(inst_last), .dp_valid(dp_valid),
        .dp_op(dp_op), .dp_ready(dp_ready)
    );

    // Decoder model: ptr indexes the op that NEXT would load
    logic [1:0] script [8];
    int         n_ops = 1;
    int         ptr = 0;

    always @(posedge clk) begin
        if (!rst_n) ptr <= 0;
        else if (inst_en) begin
            case (inst_op)
                2'b00, 2'b01: ptr <= 1;
                2'b10:        ptr <= ptr + 1;
                default:      ptr <= 0;
            endcase
        end
    end

    always_comb begin
        inst_nxt  = 2'b00;
        if (ptr < n_ops && ptr < 8) inst_nxt = script[ptr[2:0]];
        inst_last = (ptr == n_ops);
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step(input logic s, input logic m, input logic r, input logic a);
        @(negedge clk);
        start = s; start_mul = m; dp_ready = r; abort = a;
        #1;
    endtask

    task automatic load(input logic [1:0] o0, input logic [1:0] o1,
                        input logic [1:0] o2, input logic [1:0] o3, input int n);
        for (int i = 0; i < 8; i++) script[i] = 2'b00;
        script[0] = o0; script[1] = o1; script[2] = o2; script[3] = o3;
        n_ops = n;
    endtask

    typedef struct {
        logic s, m, r, a;
        logic en; logic [1:0] op; logic vld; logic [1:0] dpop;
        logic dn, er, bz; logic [CNT_W-1:0] cnt;
    } vec_t;

    vec_t tbl [8];

    initial begin
        rst_n = 1'b0; start = 1'b0; start_mul = 1'b0; abort = 1'b0; dp_ready = 1'b0;
        load(2'b00, 2'b01, 2'b10, 2'b11, 4);

        tbl[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b11, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 10'd0};
        tbl[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b01, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 10'd0};
        tbl[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b10, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 10'd0};
        tbl[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b10, 1'b1, 2'b01, 1'b0, 1'b0, 1'b1, 10'd1};
        tbl[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b10, 1'b1, 2'b10, 1'b0, 1'b0, 1'b1, 10'd2};
        tbl[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b11, 1'b1, 2'b11, 1'b0, 1'b0, 1'b1, 10'd3};
        tbl[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b11, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 10'd4};
        tbl[7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b11, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 10'd4};

        // reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst busy",     32'(busy),     32'd0);
        chk("rst done",     32'(done),     32'd0);
        chk("rst err",      32'(err),      32'd0);
        chk("rst step_cnt", 32'(step_cnt), 32'd0);
        chk("rst dp_valid", 32'(dp_valid), 32'd0);
        chk("rst dp_op",    32'(dp_op),    32'd0);
        chk("rst inst_en",  32'(inst_en),  32'd0);
        chk("rst inst_op",  32'(inst_op),  32'd3);
        rst_n = 1'b1;

        // divide, four ops, no stalls
        for (int i = 0; i < 8; i++) begin
            step(tbl[i].s, tbl[i].m, tbl[i].r, tbl[i].a);
            chk($sformatf("div[%0d] inst_en", i),  32'(inst_en),  32'(tbl[i].en));
            chk($sformatf("div[%0d] inst_op", i),  32'(inst_op),  32'(tbl[i].op));
            chk($sformatf("div[%0d] dp_valid", i), 32'(dp_valid), 32'(tbl[i].vld));
            if (tbl[i].vld)
                chk($sformatf("div[%0d] dp_op", i), 32'(dp_op), 32'(tbl[i].dpop));
            chk($sformatf("div[%0d] done", i),     32'(done),     32'(tbl[i].dn));
            chk($sformatf("div[%0d] err", i),      32'(err),      32'(tbl[i].er));
            chk($sformatf("div[%0d] busy", i),     32'(busy),     32'(tbl[i].bz));
            chk($sformatf("div[%0d] step_cnt", i), 32'(step_cnt), 32'(tbl[i].cnt));
        end

        // multiply, single op
        load(2'b10, 2'b00, 2'b00, 2'b00, 1);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        chk("mul start busy", 32'(busy), 32'd0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("mul init en", 32'(inst_en), 32'd1);
        chk("mul init op", 32'(inst_op), 32'd0);
        chk("mul init busy", 32'(busy), 32'd1);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("mul issue valid", 32'(dp_valid), 32'd1);
        chk("mul issue dp_op", 32'(dp_op), 32'd2);
        chk("mul issue en", 32'(inst_en), 32'd1);
        chk("mul issue op", 32'(inst_op), 32'd3);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("mul done", 32'(done), 32'd1);
        chk("mul err", 32'(err), 32'd0);
        chk("mul cnt", 32'(step_cnt), 32'd1);
        chk("mul done en", 32'(inst_en), 32'd0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("mul after done", 32'(done), 32'd0);
        chk("mul after busy", 32'(busy), 32'd0);

        // stall five cycles on the second op
        load(2'b00, 2'b01, 2'b10, 2'b00, 3);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("stall init op", 32'(inst_op), 32'd0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("stall op0 inst_op", 32'(inst_op), 32'd2);
        chk("stall op0 dp_op", 32'(dp_op), 32'd0);
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0);
            chk($sformatf("stall[%0d] valid", k), 32'(dp_valid), 32'd1);
            chk($sformatf("stall[%0d] dp_op", k), 32'(dp_op), 32'd1);
            chk($sformatf("stall[%0d] en", k), 32'(inst_en), 32'd0);
        end
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("stall release dp_op", 32'(dp_op), 32'd1);
        chk("stall release en", 32'(inst_en), 32'd1);
        chk("stall release op", 32'(inst_op), 32'd2);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("stall last dp_op", 32'(dp_op), 32'd2);
        chk("stall last op", 32'(inst_op), 32'd3);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("stall done", 32'(done), 32'd1);
        chk("stall err", 32'(err), 32'd0);
        chk("stall cnt", 32'(step_cnt), 32'd3);
        step(1'b0, 1'b0, 1'b0, 1'b0);

        // timeout at MAX_STEPS=4 with inst_last never set
        load(2'b00, 2'b00, 2'b00, 2'b00, 8);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b0, 1'b1, 1'b0);
            chk($sformatf("tmo hs%0d op", k + 1), 32'(inst_op), 32'd2);
        end
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("tmo hs4 cnt", 32'(step_cnt), 32'd3);
        chk("tmo hs4 en", 32'(inst_en), 32'd1);
        chk("tmo hs4 op", 32'(inst_op), 32'd3);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("tmo done", 32'(done), 32'd1);
        chk("tmo err", 32'(err), 32'd1);
        chk("tmo cnt", 32'(step_cnt), 32'd4);
        chk("tmo valid", 32'(dp_valid), 32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("tmo idle busy", 32'(busy), 32'd0);

        // abort with ready on the third op; start while busy is ignored
        load(2'b00, 2'b01, 2'b10, 2'b11, 4);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("abt init op", 32'(inst_op), 32'd1);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        chk("abt busy start", 32'(busy), 32'd1);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        chk("abt dp_op", 32'(dp_op), 32'd2);
        chk("abt en", 32'(inst_en), 32'd1);
        chk("abt op", 32'(inst_op), 32'd3);
        chk("abt cnt before", 32'(step_cnt), 32'd2);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("abt done", 32'(done), 32'd1);
        chk("abt err", 32'(err), 32'd1);
        chk("abt cnt", 32'(step_cnt), 32'd2);
        chk("abt valid", 32'(dp_valid), 32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("abt idle busy", 32'(busy), 32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("abt in idle en", 32'(inst_en), 32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("abt in idle busy", 32'(busy), 32'd0);
        chk("abt in idle done", 32'(done), 32'd0);

        // reset mid-ISSUE, then a normal run
        load(2'b00, 2'b01, 2'b10, 2'b00, 3);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("mrst pre valid", 32'(dp_valid), 32'd1);
        chk("mrst pre cnt", 32'(step_cnt), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mrst comb en", 32'(inst_en), 32'd0);
        chk("mrst comb op", 32'(inst_op), 32'd3);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("mrst busy", 32'(busy), 32'd0);
        chk("mrst valid", 32'(dp_valid), 32'd0);
        chk("mrst en", 32'(inst_en), 32'd0);
        chk("mrst op", 32'(inst_op), 32'd3);
        chk("mrst cnt", 32'(step_cnt), 32'd0);
        load(2'b10, 2'b00, 2'b00, 2'b00, 1);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("mrst run init op", 32'(inst_op), 32'd0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("mrst run dp_op", 32'(dp_op), 32'd2);
        chk("mrst run clear", 32'(inst_op), 32'd3);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("mrst run done", 32'(done), 32'd1);
        chk("mrst run err", 32'(err), 32'd0);
        chk("mrst run cnt", 32'(step_cnt), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
